// File: rtl/seg_pkg.sv
// Shared types and constants for the two-digit 7-segment multiplex scheduler.
package seg_pkg;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low cathode patterns {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-7-segment decoder, active-low {g..a}.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG[hex];

endmodule

// File: rtl/seg_mux_scheduler.sv
// Alternates two common-anode digits on one cathode bus, with blanking dead time
// before each digit and once-per-frame capture of both digit values.
module seg_mux_scheduler
  import seg_pkg::*;
#(
  parameter int unsigned ON_CYCLES    = 24000,
  parameter int unsigned BLANK_CYCLES = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic       an0,
  output logic       an1,
  output logic       frame_tick
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  // Guard keeps the counter at least one bit wide when both durations are 1.
  localparam int unsigned CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] ON_LOAD    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    d0_q, d0_d;
  logic [3:0]    d1_q, d1_d;
  logic [6:0]    seg_q, seg_d;
  logic          an0_q, an0_d;
  logic          an1_q, an1_d;
  logic          tick_q, tick_d;
  logic [6:0]    seg0_c, seg1_c;

  // Decode the next-cycle digit values so a freshly captured digit shows on entry.
  hex7seg_dec u_dec0 (
    .hex   (d0_d),
    .seg_c (seg0_c)
  );

  hex7seg_dec u_dec1 (
    .hex   (d1_d),
    .seg_c (seg1_c)
  );

  // Next-state, dwell counter and digit capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    d0_d    = d0_q;
    d1_d    = d1_q;
    tick_d  = 1'b0;
    if (!enable) begin
      state_d = BLANK0;
      cnt_d   = BLANK_LOAD;
    end else if (cnt_q == '0) begin
      unique case (state_q)
        BLANK0: begin
          state_d = SHOW0;
          cnt_d   = ON_LOAD;
          d0_d    = s0;
          d1_d    = s1;
          tick_d  = 1'b1;
        end
        SHOW0: begin
          state_d = BLANK1;
          cnt_d   = BLANK_LOAD;
        end
        BLANK1: begin
          state_d = SHOW1;
          cnt_d   = ON_LOAD;
        end
        SHOW1: begin
          state_d = BLANK0;
          cnt_d   = BLANK_LOAD;
        end
      endcase
    end
  end

  // Output pins follow the next state so they line up with the state register.
  always_comb begin
    an0_d = 1'b1;
    an1_d = 1'b1;
    seg_d = SEG_OFF;
    unique case (state_d)
      SHOW0: begin
        an0_d = 1'b0;
        seg_d = seg0_c;
      end
      SHOW1: begin
        an1_d = 1'b0;
        seg_d = seg1_c;
      end
      default: begin
        an0_d = 1'b1;
        an1_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BLANK0;
      cnt_q   <= BLANK_LOAD;
      d0_q    <= 4'h0;
      d1_q    <= 4'h0;
      seg_q   <= SEG_OFF;
      an0_q   <= 1'b1;
      an1_q   <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      seg_q   <= seg_d;
      an0_q   <= an0_d;
      an1_q   <= an1_d;
      tick_q  <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an0        = an0_q;
  assign an1        = an1_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Directed bench for seg_mux_scheduler: a 4/2 instance for the main scenarios and a 1/1 instance for the minimal frame.
module tb_seg_mux_scheduler;

  logic       clk;
  logic       reset, enable;
  logic [3:0] s0, s1;
  logic [6:0] seg;
  logic       an0, an1, frame_tick;

  logic       reset_b, enable_b;
  logic [3:0] s0_b, s1_b;
  logic [6:0] seg_b;
  logic       an0_b, an1_b, frame_tick_b;

  int n_chk = 0;
  int n_err = 0;
  logic mon_on = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg_mux_scheduler #(.ON_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .s0         (s0),
    .s1         (s1),
    .seg        (seg),
    .an0        (an0),
    .an1        (an1),
    .frame_tick (frame_tick)
  );

  seg_mux_scheduler #(.ON_CYCLES(1), .BLANK_CYCLES(1)) dut_min (
    .clk        (clk),
    .reset      (reset_b),
    .enable     (enable_b),
    .s0         (s0_b),
    .s1         (s1_b),
    .seg        (seg_b),
    .an0        (an0_b),
    .an1        (an1_b),
    .frame_tick (frame_tick_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] obs_a();
    return 32'({frame_tick, an0, an1, seg});
  endfunction

  function automatic logic [31:0] obs_b();
    return 32'({frame_tick_b, an0_b, an1_b, seg_b});
  endfunction

  // Expected {frame_tick, an0, an1, seg} for cycle c counted from the first BLANK0 cycle.
  function automatic logic [31:0] exp_vec(input int c, input int on, input int bl,
                                          input logic [6:0] g0, input logic [6:0] g1);
    int p;
    p = c % (2 * (on + bl));
    if (p < bl)                return 32'({3'b011, 7'h7F});
    else if (p < bl + on)      return 32'({(p == bl), 2'b01, g0});
    else if (p < 2 * bl + on)  return 32'({3'b011, 7'h7F});
    else                       return 32'({3'b010, g1});
  endfunction

  // Anodes must never both be low on either instance.
  always @(negedge clk) begin
    if (mon_on) begin
      check("an_excl", 32'(an0 | an1), 32'd1);
      check("an_excl_min", 32'(an0_b | an1_b), 32'd1);
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; s0 = 4'h0; s1 = 4'h0;
    reset_b = 1'b1; enable_b = 1'b1; s0_b = 4'h5; s1_b = 4'hC;

    // Reset state and first two frames with s0=1, s1=8.
    s0 = 4'h1; s1 = 4'h8;
    reset = 1'b1;
    repeat (3) step();
    mon_on = 1'b1;
    check("reset_vals", obs_a(), 32'({3'b011, 7'h7F}));
    reset = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      check($sformatf("basic_c%0d", c), obs_a(), exp_vec(c, 4, 2, seg_tab[1], seg_tab[8]));
      step();
    end

    // Mid-frame s0 change is deferred to the next frame.
    s0 = 4'hA; s1 = 4'h8;
    do_reset(2);
    for (int c = 0; c <= 14; c++) begin
      if (c == 4) s0 = 4'hF;
      check($sformatf("defer_c%0d", c), obs_a(),
            exp_vec(c, 4, 2, (c < 12) ? seg_tab[10] : seg_tab[15], seg_tab[8]));
      step();
    end

    // Sweep all 16 codes through digit 0, one per frame.
    s1 = 4'h0;
    do_reset(2);
    for (int f = 0; f < 16; f++) begin
      s0 = 4'(f);
      step();
      step();
      check($sformatf("sweep_%0d", f), obs_a(), 32'({3'b101, seg_tab[f]}));
      repeat (10) step();
    end

    // enable low for cycles 9..13, then a full BLANK0 before SHOW0.
    s0 = 4'h1; s1 = 4'h8;
    do_reset(2);
    for (int c = 0; c <= 16; c++) begin
      if (c == 9)  enable = 1'b0;
      if (c == 14) enable = 1'b1;
      if (c < 10)
        check($sformatf("en_c%0d", c), obs_a(), exp_vec(c, 4, 2, seg_tab[1], seg_tab[8]));
      else if (c < 16)
        check($sformatf("en_c%0d", c), obs_a(), 32'({3'b011, 7'h7F}));
      else
        check($sformatf("en_c%0d", c), obs_a(), 32'({3'b101, seg_tab[1]}));
      step();
    end

    // Reset during the third SHOW1 cycle aborts immediately; new frame recaptures s0=0.
    s0 = 4'h1; s1 = 4'h8;
    do_reset(2);
    for (int c = 0; c <= 10; c++) begin
      check($sformatf("abort_c%0d", c), obs_a(), exp_vec(c, 4, 2, seg_tab[1], seg_tab[8]));
      if (c == 10) begin
        reset = 1'b1;
        s0 = 4'h0;
      end
      step();
    end
    check("abort_reset_vals", obs_a(), 32'({3'b011, 7'h7F}));
    reset = 1'b0;
    for (int c = 0; c <= 2; c++) begin
      check($sformatf("recap_c%0d", c), obs_a(), exp_vec(c, 4, 2, seg_tab[0], seg_tab[8]));
      step();
    end

    // Minimal 1/1 instance gives a 4-cycle frame.
    check("min_reset_vals", obs_b(), 32'({3'b011, 7'h7F}));
    reset_b = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("min_c%0d", c), obs_b(), exp_vec(c, 1, 1, seg_tab[5], seg_tab[12]));
      step();
    end

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_mux_scheduler.md
# seg_mux_scheduler

Time-multiplexing scheduler that shares one 7-segment cathode bus between two common-anode digits. It alternates the digits with dead-time blanking between them to prevent ghosting. Both hex digit values are captured once per frame so a digit never changes mid-frame. It sits between the switch/DIP inputs and the board's seg/anode pins, driving the 7-segment resource that the single-digit labs drove directly.

## Interface

Parameters:
- ON_CYCLES, default 24000: clock cycles each digit is lit per frame; must be ≥1.
- BLANK_CYCLES, default 240: clock cycles of all-off dead time before each digit; must be ≥1.
- CW, default $clog2(max(ON_CYCLES,BLANK_CYCLES)): counter width (derived, not overridden).

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: system clock; all state changes on posedge.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: 0 forces display dark and restarts the frame.
- s0, input, 4: hex value for digit 0.
- s1, input, 4: hex value for digit 1.
- seg, output, 7: cathodes {g,f,e,d,c,b,a}, active-low, registered.
- an0, output, 1: digit 0 anode enable, active-low, registered.
- an1, output, 1: digit 1 anode enable, active-low, registered.
- frame_tick, output, 1: one-cycle pulse in the first SHOW0 cycle of each frame.

## Operation

- States, visited in a fixed cycle: BLANK0 → SHOW0 → BLANK1 → SHOW1 → BLANK0.
- Down-counter `cnt` (CW bits) is loaded on each state entry with the new state's duration minus 1.
- The state advances when `cnt`==0.
- Frame length is 2·(ON_CYCLES+BLANK_CYCLES) cycles.
- Digit capture: registers d0/d1 load s0/s1 on the edge BLANK0→SHOW0, and only then. Input changes at any other time are invisible until the next frame.
- Outputs are registered from the next state, so they are aligned with the state register:
  - BLANK0/BLANK1: an0=1, an1=1, seg=7'h7F.
  - SHOW0: an0=0, an1=1, seg=dec(d0).
  - SHOW1: an0=1, an1=0, seg=dec(d1).
- At no cycle are both an0 and an1 low.
- Decoder (active-low, {g..a}), examples:
  - 0→100_0000, 1→111_1001, 8→000_0000.
  - A→000_1000, F→000_1110.
  - All 16 codes are defined; there are no don't-cares.
- enable=0: next state is BLANK0 with `cnt` loaded to BLANK_CYCLES−1 and held. Outputs are blank and frame_tick=0. When enable returns to 1, a full BLANK0 runs before SHOW0.
- reset=1: same target as enable=0, and additionally d0=d1=0. Reset wins over enable.
- Reset mid-operation aborts immediately, with no completion of the current digit.

## Timing

- Reset values: state=BLANK0, cnt=BLANK_CYCLES−1, d0=d1=0, seg=7'h7F, an0=an1=1, frame_tick=0.
- After reset deasserts at edge E0 with enable=1:
  - BLANK0 occupies cycles 0..BLANK_CYCLES−1.
  - The first SHOW0 cycle is cycle BLANK_CYCLES. an0 goes low and frame_tick=1 in that cycle.
- Input-to-display latency: from the s0 change to the next BLANK0→SHOW0 edge, worst case one full frame.
- Blank dead time between one anode deasserting and the other asserting is exactly BLANK_CYCLES cycles.
- BLANK_CYCLES=1 and ON_CYCLES=1 are legal and must yield a 4-cycle frame.
- Simultaneous events:
  - enable falls in the same cycle as a state transition: the enable=0 behaviour takes precedence.
  - s0 changes on the capture edge: the value present at that edge is captured.

## Structure

- Package seg_pkg holds:
  - the state enum typedef (BLANK0, SHOW0, BLANK1, SHOW1);
  - SEG_OFF=7'h7F;
  - the 16-entry active-low hex segment constant table.
- Sub-module hex7seg_dec (combinational, 4-bit in, 7-bit active-low out) is instantiated twice, or once with a digit-select mux before it.
- The FSM, counter, capture registers and output registers live in seg_mux_scheduler.

## Test plan

All scenarios use ON_CYCLES=4, BLANK_CYCLES=2, giving a 12-cycle frame.
1. Reset held 3 cycles, then released with enable=1, s0=1, s1=8 → cycles 0-1: seg=7F, an=11; cycles 2-5: an0=0, seg=111_1001, frame_tick=1 in cycle 2 only; 6-7 blank; 8-11: an1=0, seg=000_0000; cycle 14: frame_tick again.
2. With s0=A, change s0 to F in cycle 4 → SHOW0 shows 000_1000 through cycle 5, and 000_1110 from cycle 14.
3. Sweep all 16 values on s0 across 16 frames → seg matches the decoder table each SHOW0; an0 and an1 are never both 0 (assertion on every cycle).
4. Drop enable in cycle 9 for 5 cycles → outputs blank from cycle 10. On re-enable, 2 blank cycles occur, then SHOW0 with frame_tick.
5. Assert reset in cycle 3 of SHOW1 → next cycle: all outputs at reset values, d0=d1=0. Display shows 100_0000 if s0 was 0 at recapture.
6. ON_CYCLES=1, BLANK_CYCLES=1 → 4-cycle frame: an0 low once and an1 low once, separated by one blank cycle.
